// File: rtl/toggle_vector_checker.sv
// Checks a WIDTH-bit toggle vector for the all-0 / all-1 alternating pattern and
// reports deviating cycles as records on a valid/ready port, with a saturating counter.
module toggle_vector_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                     c,
  input  logic                     r,
  input  logic [WIDTH-1:0]         a,
  input  logic                     en,
  input  logic                     err_ready,
  output logic                     err_valid,
  output logic [WIDTH-1:0]         err_mask,
  output logic [$clog2(WIDTH)-1:0] err_index,
  output logic [CNT_W-1:0]         err_count,
  output logic                     err_dropped,
  output logic                     locked
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;

  logic [1:0]       r_state;
  logic             r_exp;
  logic             r_locked;
  logic             r_valid;
  logic [WIDTH-1:0] r_mask;
  logic [IW-1:0]    r_index;
  logic [CNT_W-1:0] r_count;
  logic             r_dropped;

  logic [1:0]       w_next;
  logic             w_uniform;
  logic [WIDTH-1:0] w_mism;
  logic             w_err;
  logic             w_accept;
  logic [IW-1:0]    w_low;

  assign w_uniform = (a == '0) || (a == '1);
  assign w_mism    = a ^ {WIDTH{r_exp}};
  assign w_err     = (r_state == ARMED) && en && (w_mism != '0);
  assign w_accept  = r_valid && err_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = SYNC;
      SYNC:    if (!en) w_next = IDLE;
               else if (w_uniform) w_next = ARMED;
      ARMED:   if (!en) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    w_low = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_mism[i]) w_low = IW'(i);
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      r_state   <= IDLE;
      r_exp     <= 1'b0;
      r_locked  <= 1'b0;
      r_valid   <= 1'b0;
      r_mask    <= '0;
      r_index   <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_locked <= (w_next == ARMED);

      if (r_state == SYNC && en && w_uniform) begin
        r_exp <= ~a[0];
      end else if (r_state == ARMED && en) begin
        r_exp <= ~r_exp;
      end

      if (w_err) begin
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
        // A record accepted this cycle frees the slot for the new one.
        if (!r_valid || w_accept) begin
          r_valid <= 1'b1;
          r_mask  <= w_mism;
          r_index <= w_low;
        end else begin
          r_dropped <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign err_valid   = r_valid;
  assign err_mask    = r_mask;
  assign err_index   = r_index;
  assign err_count   = r_count;
  assign err_dropped = r_dropped;
  assign locked      = r_locked;

endmodule

// File: tb/tb_toggle_vector_checker.sv
// Directed bench for toggle_vector_checker: a spec-level model checked every cycle,
// plus literal expectations for the key scenarios (two instances, CNT_W=16 and CNT_W=4).
module tb_toggle_vector_checker;

  logic        c = 1'b0;
  logic        r = 1'b0;
  logic [31:0] a = '0;
  logic        en = 1'b0;
  logic        err_ready = 1'b0;

  logic        err_valid, err_dropped, locked;
  logic [31:0] err_mask;
  logic [4:0]  err_index;
  logic [15:0] err_count;

  logic        v4, d4, l4;
  logic [31:0] m4;
  logic [4:0]  i4;
  logic [3:0]  c4;

  int checks = 0;
  int errors = 0;

  toggle_vector_checker #(.WIDTH(32), .CNT_W(16)) dut (
    .c(c), .r(r), .a(a), .en(en), .err_ready(err_ready),
    .err_valid(err_valid), .err_mask(err_mask), .err_index(err_index),
    .err_count(err_count), .err_dropped(err_dropped), .locked(locked)
  );

  toggle_vector_checker #(.WIDTH(32), .CNT_W(4)) dut4 (
    .c(c), .r(r), .a(a), .en(en), .err_ready(err_ready),
    .err_valid(v4), .err_mask(m4), .err_index(i4),
    .err_count(c4), .err_dropped(d4), .locked(l4)
  );

  always #5 c = ~c;

  // Model state in spec terms: mode 0=idle, 1=searching for a uniform word, 2=checking.
  bit          modelOn = 0;
  int          mMode = 0;
  bit          mExp = 0;
  bit          mValid = 0;
  bit          mDropped = 0;
  logic [31:0] mMask = '0;
  int          mIndex = 0;
  int          mCount = 0;
  int          mCount4 = 0;

  function automatic int lowestBit(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge c) begin
    logic [31:0] mism;
    bit accept, isErr;
    if (r) begin
      modelOn = 1;
      mMode = 0; mExp = 0; mValid = 0; mDropped = 0;
      mMask = '0; mIndex = 0; mCount = 0; mCount4 = 0;
    end else if (modelOn) begin
      mism   = a ^ (mExp ? 32'hFFFF_FFFF : 32'h0);
      accept = mValid && err_ready;
      isErr  = (mMode == 2) && en && (mism != 0);
      if (isErr) begin
        mCount  = (mCount + 1 > 65535) ? 65535 : mCount + 1;
        mCount4 = (mCount4 + 1 > 15) ? 15 : mCount4 + 1;
        if (!mValid || accept) begin
          mValid = 1; mMask = mism; mIndex = lowestBit(mism);
        end else begin
          mDropped = 1;
        end
      end else if (accept) begin
        mValid = 0;
      end
      if (!en) mMode = 0;
      else if (mMode == 0) mMode = 1;
      else if (mMode == 1) begin
        if (a == 32'h0 || a == 32'hFFFF_FFFF) begin
          mExp = !a[0]; mMode = 2;
        end
      end else mExp = !mExp;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge c) begin
    if (modelOn) begin
      checkOutput("model err_valid", 32'(err_valid), 32'(mValid));
      checkOutput("model err_mask", err_mask, mMask);
      checkOutput("model err_index", 32'(err_index), 32'(mIndex));
      checkOutput("model err_count", 32'(err_count), 32'(mCount));
      checkOutput("model err_dropped", 32'(err_dropped), 32'(mDropped));
      checkOutput("model locked", 32'(locked), 32'(mMode == 2));
      checkOutput("model cnt4 err_count", 32'(c4), 32'(mCount4));
    end
  end

  bit curExp = 0;

  task automatic applyStimulus(input logic [31:0] va, input logic ven, input logic vrdy);
    r = 1'b0; a = va; en = ven; err_ready = vrdy;
    @(posedge c); #1;
  endtask

  task automatic resetDut();
    r = 1'b1; a = '0; en = 1'b0; err_ready = 1'b0;
    @(posedge c); #1;
    r = 1'b0;
  endtask

  task automatic armedCycle(input logic [31:0] bits, input logic vrdy);
    applyStimulus((curExp ? 32'hFFFF_FFFF : 32'h0) ^ bits, 1'b1, vrdy);
    curExp = !curExp;
  endtask

  task automatic armFromReset();
    resetDut();
    applyStimulus(32'h0, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0);
    curExp = 0;
  endtask

  initial begin
    bit sawValid;
    @(posedge c); #1;
    resetDut();
    resetDut();
    checkOutput("reset err_valid", 32'(err_valid), 0);
    checkOutput("reset err_mask", err_mask, 0);
    checkOutput("reset err_index", 32'(err_index), 0);
    checkOutput("reset err_count", 32'(err_count), 0);
    checkOutput("reset err_dropped", 32'(err_dropped), 0);
    checkOutput("reset locked", 32'(locked), 0);

    sawValid = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus((i % 2) ? 32'hFFFF_FFFF : 32'h0, 1'b1, 1'b0);
      if (err_valid) sawValid = 1;
      if (i == 0) checkOutput("locked after cycle 0", 32'(locked), 0);
      if (i == 1) checkOutput("locked from cycle 2", 32'(locked), 1);
    end
    checkOutput("clean run err_valid seen", 32'(sawValid), 0);
    checkOutput("clean run err_count", 32'(err_count), 0);
    checkOutput("clean run locked", 32'(locked), 1);

    curExp = 0;
    armedCycle(32'h0000_0020, 1'b0);
    checkOutput("bit5 err_valid", 32'(err_valid), 1);
    checkOutput("bit5 err_mask", err_mask, 32'h0000_0020);
    checkOutput("bit5 err_index", 32'(err_index), 5);
    checkOutput("bit5 err_count", 32'(err_count), 1);
    armedCycle(32'h0, 1'b1);
    checkOutput("accept err_valid", 32'(err_valid), 0);
    checkOutput("accept mask kept", err_mask, 32'h0000_0020);

    armFromReset();
    armedCycle(32'h0000_0008, 1'b0);
    armedCycle(32'h0000_0080, 1'b0);
    armedCycle(32'h0000_0200, 1'b0);
    checkOutput("drop err_mask held", err_mask, 32'h0000_0008);
    checkOutput("drop err_index held", 32'(err_index), 3);
    checkOutput("drop err_count", 32'(err_count), 3);
    checkOutput("drop err_dropped", 32'(err_dropped), 1);

    armedCycle(32'h8000_0000, 1'b1);
    checkOutput("swap err_valid", 32'(err_valid), 1);
    checkOutput("swap err_mask", err_mask, 32'h8000_0000);
    checkOutput("swap err_index", 32'(err_index), 31);
    checkOutput("swap err_count", 32'(err_count), 4);
    armedCycle(32'h0, 1'b1);
    checkOutput("drain err_valid", 32'(err_valid), 0);
    checkOutput("drain mask kept", err_mask, 32'h8000_0000);
    checkOutput("dropped sticky", 32'(err_dropped), 1);

    armFromReset();
    for (int i = 0; i < 20; i++) armedCycle(32'h0000_0001, 1'b1);
    checkOutput("cnt4 saturated", 32'(c4), 15);
    checkOutput("cnt16 count", 32'(err_count), 20);

    resetDut();
    applyStimulus(32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(32'h0000_FFFF, 1'b1, 1'b0);
    checkOutput("sync nonuniform locked", 32'(locked), 0);
    checkOutput("sync nonuniform count", 32'(err_count), 0);
    applyStimulus(32'h0, 1'b1, 1'b0);
    checkOutput("sync uniform locked", 32'(locked), 1);
    curExp = 1;
    armedCycle(32'h0, 1'b0);
    checkOutput("after sync no error", 32'(err_valid), 0);

    armedCycle(32'h0000_0004, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("exit record survives", 32'(err_valid), 1);
    checkOutput("exit locked", 32'(locked), 0);
    checkOutput("exit err_index", 32'(err_index), 2);
    applyStimulus(32'h0, 1'b0, 1'b1);
    checkOutput("exit handshake done", 32'(err_valid), 0);

    armFromReset();
    armedCycle(32'h0000_0010, 1'b0);
    checkOutput("pre-reset err_valid", 32'(err_valid), 1);
    resetDut();
    checkOutput("mid reset err_valid", 32'(err_valid), 0);
    checkOutput("mid reset err_mask", err_mask, 0);
    checkOutput("mid reset err_index", 32'(err_index), 0);
    checkOutput("mid reset err_count", 32'(err_count), 0);
    checkOutput("mid reset locked", 32'(locked), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
